lz77_dec_sched: RTL and testbench

Codeword scheduler for the LZ77 decoder datapath. It accepts (pos, len, char) codewords from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. Each codeword is held stable on the datapath inputs for exactly len+1 stepping cycles, and the datapath step enable is asserted only when a codeword is present. The block sits between the codeword source and the decoder datapath, and reports stream completion when the end-marker codeword has been fully consumed.

---
 rtl/lz77_dec_sched_if.sv | 25 ++
 rtl/lz77_dec_sched.sv | 185 ++++++++++++++++++
 tb/tb_lz77_dec_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lz77_dec_sched_if.sv
// Codeword channel between the LZ77 codeword producer and the decoder scheduler.
// The producer drives a (pos, len, char) word under cw_valid; the scheduler answers with cw_ready.
interface lz77_dec_sched_if;
    logic       cw_valid;
    logic       cw_ready;
    logic [3:0] cw_pos;
    logic [2:0] cw_len;
    logic [7:0] cw_char;

    modport master (
        output cw_valid,
        output cw_pos,
        output cw_len,
        output cw_char,
        input  cw_ready
    );

    modport slave (
        input  cw_valid,
        input  cw_pos,
        input  cw_len,
        input  cw_char,
        output cw_ready
    );
endinterface

// File: rtl/lz77_dec_sched.sv
// LZ77 decoder codeword scheduler: buffers codewords in a small FIFO and holds each one
// on the datapath inputs for len+1 stepping cycles, flagging completion after the end marker.
module lz77_dec_sched #(
    parameter int          DEPTH    = 4,
    parameter logic [7:0]  END_CHAR = 8'h24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    lz77_dec_sched_if.slave    cw,
    output logic [3:0]         dec_pos,
    output logic [2:0]         dec_len,
    output logic [7:0]         dec_char,
    output logic               dec_run,
    output logic               dec_first,
    output logic               busy,
    output logic               done,
    output logic [15:0]        stall_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [3:0] pos;
        logic [2:0] len;
        logic [7:0] ch;
    } cw_t;

    state_t        state;
    state_t        state_nxt;

    cw_t           mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [2:0]    cnt;
    logic          first_pend;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          arm;
    logic          flush;
    logic          last_cycle;
    logic          is_end;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign arm        = start && (state == S_IDLE || state == S_DONE);
    assign flush      = start && (state == S_DONE);
    assign last_cycle = (state == S_RUN) && (cnt == dec_len);
    assign is_end     = (dec_char == END_CHAR);
    assign push       = cw.cw_valid && cw.cw_ready;
    // A pop happens either when WAIT finds work or when a non-final codeword ends with work queued.
    assign pop        = !empty && ((state == S_WAIT) || (last_cycle && !is_end));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment up front keeps this block purely combinational (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!empty) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (last_cycle) begin
                    if (is_end)     state_nxt = S_DONE;
                    else if (empty) state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                if (start) state_nxt = S_WAIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the state register
    // ------------------------------------------------------------------
    always_comb begin
        cw.cw_ready = !full && (state != S_DONE);
        dec_run     = (state == S_RUN);
        dec_first   = (state == S_RUN) && first_pend;
        busy        = (state == S_WAIT) || (state == S_RUN);
        done        = (state == S_DONE);
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the array is left unreset; occupancy guards every read, so stale entries are never used.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cw.cw_pos, cw.cw_len, cw.cw_char};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Leftovers queued behind the end marker are discarded on restart.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Current codeword and stepping counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_pos  <= '0;
            dec_len  <= '0;
            dec_char <= '0;
            cnt      <= '0;
        end else if (pop) begin
            dec_pos  <= mem[rd_ptr].pos;
            dec_len  <= mem[rd_ptr].len;
            dec_char <= mem[rd_ptr].ch;
            cnt      <= '0;
        end else if (state == S_RUN && !last_cycle) begin
            cnt <= cnt + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stream bookkeeping: stall counter and first-step flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            first_pend <= 1'b0;
        end else begin
            if (arm) begin
                stall_cnt <= '0;
            end else if (state == S_WAIT && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end

            if (arm) begin
                first_pend <= 1'b1;
            end else if (state == S_RUN) begin
                first_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lz77_dec_sched.sv
// Self-checking bench for lz77_dec_sched: a queue-based stream model checked every cycle,
// plus directed scenarios with hand-computed traces and stall counts.
module tb_lz77_dec_sched;

    localparam int         DEPTH    = 4;
    localparam logic [7:0] END_CHAR = 8'h24;

    typedef struct packed {
        logic [3:0] pos;
        logic [2:0] len;
        logic [7:0] ch;
    } cw_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  dec_pos;
    logic [2:0]  dec_len;
    logic [7:0]  dec_char;
    logic        dec_run;
    logic        dec_first;
    logic        busy;
    logic        done;
    logic [15:0] stall_cnt;

    lz77_dec_sched_if cwif ();

    lz77_dec_sched #(
        .DEPTH    (DEPTH),
        .END_CHAR (END_CHAR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cw        (cwif.slave),
        .dec_pos   (dec_pos),
        .dec_len   (dec_len),
        .dec_char  (dec_char),
        .dec_run   (dec_run),
        .dec_first (dec_first),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Stream model: a queue of pending words, the word on the datapath and
    // how many stepping cycles it still owes.
    // ------------------------------------------------------------------
    cw_t         m_q[$];
    cw_t         m_cur    = '0;
    int          m_left   = 0;
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_first  = 1'b0;
    logic [15:0] m_stall  = '0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_q.delete();
            m_cur    = '0;
            m_left   = 0;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_first  = 1'b0;
            m_stall  = '0;
        end else begin
            bit  take;
            cw_t w;
            take = cwif.cw_valid && (m_q.size() < DEPTH) && !m_done;
            w    = {cwif.cw_pos, cwif.cw_len, cwif.cw_char};
            if (start && !m_active) begin
                if (m_done) m_q.delete();
                m_done   = 1'b0;
                m_active = 1'b1;
                m_stall  = '0;
                m_first  = 1'b1;
            end else if (m_active) begin
                if (m_left == 0) begin
                    if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
                    if (m_q.size() > 0) begin
                        m_cur  = m_q.pop_front();
                        m_left = int'(m_cur.len) + 1;
                    end
                end else begin
                    m_first = 1'b0;
                    m_left  = m_left - 1;
                    if (m_left == 0) begin
                        if (m_cur.ch == END_CHAR) begin
                            m_done   = 1'b1;
                            m_active = 1'b0;
                        end else if (m_q.size() > 0) begin
                            m_cur  = m_q.pop_front();
                            m_left = int'(m_cur.len) + 1;
                        end
                    end
                end
            end
            if (take) m_q.push_back(w);
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare and trace capture on the falling edge
    // ------------------------------------------------------------------
    bit         cmp_en         = 1'b0;
    logic [7:0] trace[$];
    int         trace_cyc[$];
    int         first_cnt      = 0;
    bit         saw_not_ready  = 1'b0;
    int         cyc            = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (cmp_en && !reset) begin
            check("cw_ready",  32'(cwif.cw_ready), 32'((m_q.size() < DEPTH) && !m_done));
            check("dec_run",   32'(dec_run),       32'(m_left > 0));
            check("dec_first", 32'(dec_first),     32'((m_left > 0) && m_first));
            check("busy",      32'(busy),          32'(m_active));
            check("done",      32'(done),          32'(m_done));
            check("stall_cnt", 32'(stall_cnt),     32'(m_stall));
            check("dec_pos",   32'(dec_pos),       32'(m_cur.pos));
            check("dec_len",   32'(dec_len),       32'(m_cur.len));
            check("dec_char",  32'(dec_char),      32'(m_cur.ch));
        end
        if (dec_run === 1'b1) begin
            trace.push_back(dec_char);
            trace_cyc.push_back(cyc);
            if (dec_first === 1'b1) first_cnt++;
        end
        if (cwif.cw_ready === 1'b0 && busy === 1'b1) saw_not_ready = 1'b1;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at, or just after, a falling edge)
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        start         = 1'b0;
        cwif.cw_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push_word(input logic [3:0] pos, input logic [2:0] len, input logic [7:0] ch);
        bit acc;
        cwif.cw_valid = 1'b1;
        cwif.cw_pos   = pos;
        cwif.cw_len   = len;
        cwif.cw_char  = ch;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = cwif.cw_ready;
            @(negedge clk);
        end
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drop_valid();
        cwif.cw_valid = 1'b0;
    endtask

    task automatic clear_trace();
        trace.delete();
        trace_cyc.delete();
        first_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic check_trace(input string tag, input string exp, input bit contiguous);
        int n;
        check({tag, "_len"}, 32'(trace.size()), 32'(exp.len()));
        n = (trace.size() < exp.len()) ? trace.size() : exp.len();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_char%0d", tag, i), 32'(trace[i]), 32'(exp[i]));
        end
        if (trace.size() > 0) begin
            check({tag, "_contiguous"},
                  32'((trace_cyc[trace_cyc.size()-1] - trace_cyc[0] + 1) == trace.size()),
                  32'(contiguous));
        end
        check({tag, "_first_cnt"}, 32'(first_cnt), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        string exp_s;
        string letters;

        cwif.cw_valid = 1'b0;
        cwif.cw_pos   = '0;
        cwif.cw_len   = '0;
        cwif.cw_char  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        check("rst_cw_ready",  32'(cwif.cw_ready), 32'd1);
        check("rst_dec_run",   32'(dec_run),       32'd0);
        check("rst_dec_first", 32'(dec_first),     32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_done",      32'(done),          32'd0);
        check("rst_stall",     32'(stall_cnt),     32'd0);
        check("rst_dec_word",  32'({dec_pos, dec_len, dec_char}), 32'd0);
        cmp_en = 1'b1;

        // Single end codeword preloaded in IDLE
        @(negedge clk);
        push_word(4'd0, 3'd0, END_CHAR);
        drop_valid();
        clear_trace();
        pulse_start();
        wait_done(20);
        check_trace("single", "$", 1'b1);
        check("single_stall", 32'(stall_cnt), 32'd1);

        // Back-to-back preloaded stream: 3 + 1 + 8 + 1 = 13 steps with no bubble
        do_reset();
        push_word(4'd1, 3'd2, "a");
        push_word(4'd2, 3'd0, "b");
        push_word(4'd8, 3'd7, "c");
        push_word(4'd3, 3'd0, END_CHAR);
        drop_valid();
        clear_trace();
        pulse_start();
        wait_done(60);
        check_trace("b2b", "aaabcccccccc$", 1'b1);
        check("b2b_stall", 32'(stall_cnt), 32'd1);

        // Starvation: second word arrives 5 cycles after the first
        clear_trace();
        pulse_start();
        push_word(4'd5, 3'd1, "A");
        drop_valid();
        repeat (4) @(negedge clk);
        push_word(4'd0, 3'd0, END_CHAR);
        drop_valid();
        wait_done(60);
        check_trace("starve", "AA$", 1'b0);
        check("starve_stall", 32'(stall_cnt), 32'd5);

        // Backpressure: DEPTH+2 long words with cw_valid held high
        clear_trace();
        saw_not_ready = 1'b0;
        pulse_start();
        letters = "abcde$";
        exp_s   = "";
        for (int k = 0; k < 6; k++) begin
            push_word(4'(k), 3'd7, letters[k]);
            for (int r = 0; r < 8; r++) exp_s = {exp_s, letters.substr(k, k)};
        end
        drop_valid();
        wait_done(200);
        check_trace("bp", exp_s, 1'b1);
        check("bp_ready_fell", 32'(saw_not_ready), 32'd1);

        // Reset asserted between clock edges in the middle of a RUN
        clear_trace();
        pulse_start();
        push_word(4'd2, 3'd7, "p");
        push_word(4'd0, 3'd0, END_CHAR);
        drop_valid();
        for (int i = 0; i < 20 && dec_run !== 1'b1; i++) @(negedge clk);
        check("mid_running", 32'(dec_run), 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_dec_run",  32'(dec_run),       32'd0);
        check("mid_busy",     32'(busy),          32'd0);
        check("mid_cw_ready", 32'(cwif.cw_ready), 32'd1);
        check("mid_done",     32'(done),          32'd0);
        check("mid_stall",    32'(stall_cnt),     32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        push_word(4'd4, 3'd1, "x");
        push_word(4'd0, 3'd0, END_CHAR);
        drop_valid();
        clear_trace();
        pulse_start();
        wait_done(60);
        check_trace("postrst", "xx$", 1'b1);

        // Restart from DONE with two leftovers queued behind the end marker
        do_reset();
        push_word(4'd1, 3'd2, END_CHAR);
        push_word(4'd6, 3'd0, "L");
        push_word(4'd7, 3'd3, "M");
        drop_valid();
        clear_trace();
        pulse_start();
        wait_done(60);
        check_trace("left", "$$$", 1'b1);
        repeat (3) @(negedge clk);
        check("left_done_held", 32'(done), 32'd1);
        clear_trace();
        pulse_start();
        push_word(4'd7, 3'd1, "n");
        push_word(4'd0, 3'd0, END_CHAR);
        drop_valid();
        wait_done(60);
        check_trace("restart", "nn$", 1'b1);
        check("restart_stall", 32'(stall_cnt), 32'd2);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
